// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq -- multi-cycle RV32M multiply/divide sequencer.
//
// One operand bit is processed per cycle: a shift-add multiplier for
// MUL/MULH/MULHSU/MULHU and a restoring divider for DIV/DIVU/REM/REMU.
// Signed operands are reduced to magnitudes first; the sign is restored
// in the FIX cycle. RISC-V divide-by-zero and signed-overflow results
// are forced in FIX.
//
// Ports:
//   clk_i      core clock
//   rst_i      synchronous active-high reset
//   start_i    launch request (sampled only in IDLE)
//   funct3_i   RV32M funct3 operation select
//   rs1_i      operand A (multiplicand / dividend)
//   rs2_i      operand B (multiplier / divisor)
//   flush_i    abort an in-flight operation
//   busy_o     high whenever the sequencer is not IDLE
//   done_o     one-cycle pulse, result_o valid
//   result_o   result, held until the next done_o
//
// Optional build macro MULDIV_SHORTCUT_EN: divide-by-zero, signed overflow
// and multiply-by-zero skip the iteration phase (PREP -> FIX).
// -----------------------------------------------------------------------------
module muldiv_seq #(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    state_t              r_state;
    logic [2:0]          r_f3;
    logic [XLEN-1:0]     r_rs1;
    logic [XLEN-1:0]     r_rs2;
    logic [XLEN-1:0]     r_b;       // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   r_acc;     // product, or remainder:quotient
    logic [CNT_W-1:0]    r_cnt;
    logic                r_neg;
    logic                r_div0;
    logic                r_ovf;
    logic                r_done;
    logic [XLEN-1:0]     r_result;

    function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
        return -v;
    endfunction

    function automatic logic [2*XLEN-1:0] f_neg2(input logic [2*XLEN-1:0] v);
        return -v;
    endfunction

    // PREP: operand signedness, magnitudes and special-case detection
    logic            w_is_mul;
    logic            w_sgn_a;
    logic            w_sgn_b;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_div0;
    logic            w_ovf;

    assign w_is_mul = ~r_f3[2];
    assign w_sgn_a  = (r_f3 == 3'b001) || (r_f3 == 3'b010) || (r_f3 == 3'b100) || (r_f3 == 3'b110);
    assign w_sgn_b  = (r_f3 == 3'b001) || (r_f3 == 3'b100) || (r_f3 == 3'b110);
    assign w_sa     = w_sgn_a & r_rs1[XLEN-1];
    assign w_sb     = w_sgn_b & r_rs2[XLEN-1];
    // The most negative value maps onto itself, read as unsigned 2^(XLEN-1).
    assign w_abs_a  = w_sa ? f_neg(r_rs1) : r_rs1;
    assign w_abs_b  = w_sb ? f_neg(r_rs2) : r_rs2;
    assign w_div0   = ~w_is_mul & (r_rs2 == '0);
    assign w_ovf    = ~w_is_mul & ~r_f3[0] & (r_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&r_rs2);
`ifdef MULDIV_SHORTCUT_EN
    logic            w_mul0;
    assign w_mul0   = w_is_mul & ((r_rs1 == '0) || (r_rs2 == '0));
`endif

    // CALC: one shift-add or one restoring-divide step
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_nxt;
    logic [XLEN:0]     w_div_sh;
    logic [XLEN:0]     w_div_dif;
    logic [2*XLEN-1:0] w_div_nxt;

    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_div_sh  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_div_dif = w_div_sh - {1'b0, r_b};
    // Borrow out of the trial subtraction means the divisor did not fit.
    assign w_div_nxt = w_div_dif[XLEN] ? {w_div_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                       : {w_div_dif[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    // FIX: sign restore, half/quotient/remainder select, special cases
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;

    assign w_prod = r_neg ? f_neg2(r_acc) : r_acc;
    assign w_quo  = r_neg ? f_neg(r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
    assign w_rem  = r_neg ? f_neg(r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_res = '0;
        if (w_is_mul) begin
            w_fix_res = (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        end else if (r_div0) begin
            w_fix_res = r_f3[1] ? r_rs1 : '1;
        end else if (r_ovf) begin
            w_fix_res = r_f3[1] ? '0 : r_rs1;
        end else begin
            w_fix_res = r_f3[1] ? w_rem : w_quo;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_f3     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (flush_i && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start_i && !flush_i) begin
                        r_f3    <= funct3_i;
                        r_rs1   <= rs1_i;
                        r_rs2   <= rs2_i;
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_div0 <= w_div0;
                    r_ovf  <= w_ovf;
                    r_cnt  <= CNT_W'(XLEN);
                    if (w_is_mul) begin
                        r_b   <= w_abs_a;
                        r_acc <= {{XLEN{1'b0}}, w_abs_b};
                        r_neg <= w_sa ^ w_sb;
                    end else begin
                        r_b   <= w_abs_b;
                        r_acc <= {{XLEN{1'b0}}, w_abs_a};
                        r_neg <= r_f3[1] ? w_sa : (w_sa ^ w_sb);
                    end
`ifdef MULDIV_SHORTCUT_EN
                    if (w_div0 || w_ovf || w_mul0) begin
                        r_state <= S_FIX;
                        if (w_mul0) r_acc <= '0;
                    end else begin
                        r_state <= S_CALC;
                    end
`else
                    r_state <= S_CALC;
`endif
                end
                S_CALC: begin
                    r_acc <= w_is_mul ? w_mul_nxt : w_div_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o   = (r_state != S_IDLE);
    assign done_o   = r_done;
    assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

    localparam int LAT = 35;
`ifdef MULDIV_SHORTCUT_EN
    localparam int LS = 3;
`else
    localparam int LS = 35;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge (cycle 0). Returns at the negedge of cycle lat+1.
    // With intrude set, a second start with other operands is pulsed mid-run.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input bit intrude);
        int          done_cyc;
        int          n_done;
        bit          busy_ok;
        logic [31:0] res;
        done_cyc = -1; n_done = 0; busy_ok = 1'b1; res = 'x;
        start_i = 1'b1; funct3_i = f; rs1_i = a; rs2_i = b;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (intrude && c == 5) begin
                start_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd9; rs2_i = 32'd3;
            end
            if (c <= lat && busy_o !== 1'b1) busy_ok = 1'b0;
            if (c == lat + 1 && busy_o !== 1'b0) busy_ok = 1'b0;
            if (done_o === 1'b1) begin
                n_done++;
                done_cyc = c;
            end
            if (c == lat) res = result_o;
        end
        chk({tag, " result"}, res, exp);
        chk({tag, " done_cycle"}, done_cyc, lat);
        chk({tag, " done_count"}, n_done, 1);
        chk({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, " hold"}, result_o, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n_done;
        rst_i = 1'b1; start_i = 1'b0; funct3_i = '0; rs1_i = '0; rs2_i = '0; flush_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset busy", {31'd0, busy_o}, 32'd0);
        chk("reset done", {31'd0, done_o}, 32'd0);
        chk("reset result", result_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        run_op("MUL 7x6",       3'b000, 32'd7,        32'd6,        32'd42,       LAT, 1'b0);
        run_op("MULH -1x-1",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, LAT, 1'b0);
        run_op("MULHU",         3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT, 1'b0);
        run_op("MULHSU -1x2",   3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, LAT, 1'b0);
        run_op("MULH min^2",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, LAT, 1'b0);
        run_op("MULHSU min",    3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT, 1'b0);
        run_op("DIV -7/2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT, 1'b0);
        run_op("REM -7/2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT, 1'b0);
        run_op("DIVU 100/7",    3'b101, 32'd100,      32'd7,        32'd14,       LAT, 1'b0);
        run_op("REMU 100/7",    3'b111, 32'd100,      32'd7,        32'd2,        LAT, 1'b0);
        run_op("DIV min/2",     3'b100, 32'h80000000, 32'd2,        32'hC0000000, LAT, 1'b0);
        run_op("DIV 5/0",       3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, LS,  1'b0);
        run_op("REM 5/0",       3'b110, 32'd5,        32'd0,        32'd5,        LS,  1'b0);
        run_op("REM -5/0",      3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, LS,  1'b0);
        run_op("DIVU 9/0",      3'b101, 32'd9,        32'd0,        32'hFFFFFFFF, LS,  1'b0);
        run_op("DIV ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LS,  1'b0);
        run_op("REM ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, LS,  1'b0);
        run_op("MUL 0x5",       3'b000, 32'd0,        32'd5,        32'd0,        LS,  1'b0);
        run_op("MUL 3x5 busy",  3'b000, 32'd3,        32'd5,        32'd15,       LAT, 1'b1);

        // Flush a DIVU in cycle 10; result_o must keep 15.
        n_done = 0;
        start_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd100; rs2_i = 32'd7;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (done_o === 1'b1) n_done++;
            if (c == 10) flush_i = 1'b1;
            if (c == 11) flush_i = 1'b0;
        end
        chk("flush busy", {31'd0, busy_o}, 32'd0);
        chk("flush no done", n_done, 0);
        chk("flush result", result_o, 32'd15);
        run_op("after flush",   3'b111, 32'd100,      32'd7,        32'd2,        LAT, 1'b0);

        // start together with flush in IDLE is not accepted
        start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd2; rs2_i = 32'd2;
        @(negedge clk_i);
        start_i = 1'b0; flush_i = 1'b0;
        chk("start+flush busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk_i);
        chk("start+flush idle", {31'd0, busy_o}, 32'd0);

        // Reset in cycle 20 of a MUL
        n_done = 0;
        start_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd7; rs2_i = 32'd6;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (done_o === 1'b1) n_done++;
            if (c == 20) rst_i = 1'b1;
        end
        chk("rst busy", {31'd0, busy_o}, 32'd0);
        chk("rst done", {31'd0, done_o}, 32'd0);
        chk("rst result", result_o, 32'd0);
        chk("rst no done", n_done, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst stays idle", {31'd0, busy_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
